pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up a PLL from the free-running reference clock domain. The PLL is held
// in reset for PLLRST_CYCLES, then the sequencer waits for the synchronized
// lock indication. If lock does not arrive within LOCK_TIMEOUT cycles, the PLL
// is reset again. Lock must then stay high for HOLD_CYCLES consecutive cycles
// before the PLL-clocked logic is released. A lock drop while running puts the
// downstream logic back into reset and is recorded.
//
// Configuration macro:
//   PLL_LOCK_LOSS_COUNT_EN - when defined, LOSS_COUNT is a saturating count of
//                            lock losses in RUN. When undefined, LOSS_COUNT is
//                            tied to zero and no register is built. LOCK_LOST
//                            behaves the same either way.
//
// Ports:
//   CLK          in   reference clock, free-running, independent of the PLL
//   RESET        in   asynchronous active-high reset
//   LOCK         in   PLL lock indication, asynchronous to CLK
//   PLL_RESETB   out  active-low PLL reset, low only while in PLLRST
//   SYS_RESET    out  active-high reset for PLL-clocked logic, low only in RUN
//   READY        out  high only in RUN
//   LOCK_LOST    out  sticky: lock dropped after RUN was reached
//   RETRY_COUNT  out  lock timeouts, saturating at 255
//   LOSS_COUNT   out  lock losses in RUN, saturating at 255 (or constant 0)
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int unsigned PLLRST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 12000,
    parameter int unsigned HOLD_CYCLES   = 1200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOCK,
    output logic       PLL_RESETB,
    output logic       SYS_RESET,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [7:0] RETRY_COUNT,
    output logic [7:0] LOSS_COUNT
);

    // Last counter value of each timed state; the state is left on the cycle
    // the counter holds this value, so the state lasts exactly N cycles.
    localparam logic [15:0] PLLRST_LAST  = 16'(PLLRST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLLRST    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Saturating 8-bit increment used by both event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic        lock_meta_r;
    logic        lock_sync_r;   // synchronized lock (second flop)
    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] cnt_r;
    logic        cnt_clr_s;
    logic        retry_inc_s;
    logic        loss_inc_s;
    logic        pll_resetb_r;
    logic        sys_reset_r;
    logic        ready_r;
    logic        lock_lost_r;
    logic [7:0]  retry_cnt_r;

    // Two-flop synchronizer bringing LOCK into the CLK domain.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= LOCK;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next-state decode. Lock is tested before the timeout so that a lock
    // arriving on the timeout cycle wins and does not count as a retry.
    always_comb begin
        state_nx_s  = state_r;
        cnt_clr_s   = 1'b0;
        retry_inc_s = 1'b0;
        loss_inc_s  = 1'b0;
        case (state_r)
            ST_PLLRST: begin
                if (cnt_r == PLLRST_LAST) begin
                    state_nx_s = ST_WAIT_LOCK;
                    cnt_clr_s  = 1'b1;
                end else begin
                    state_nx_s = ST_PLLRST;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_r) begin
                    state_nx_s = ST_STABLE;
                    cnt_clr_s  = 1'b1;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nx_s  = ST_PLLRST;
                    cnt_clr_s   = 1'b1;
                    retry_inc_s = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_sync_r) begin
                    state_nx_s = ST_WAIT_LOCK;
                    cnt_clr_s  = 1'b1;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nx_s = ST_RUN;
                    cnt_clr_s  = 1'b1;
                end else begin
                    state_nx_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!lock_sync_r) begin
                    state_nx_s = ST_WAIT_LOCK;
                    cnt_clr_s  = 1'b1;
                    loss_inc_s = 1'b1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_PLLRST;
                cnt_clr_s  = 1'b1;
            end
        endcase
    end

    // State register, state counter and outputs. Outputs are registered from
    // the next state so they change on the same edge as the state register and
    // track it exactly, with no decode glitches.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= ST_PLLRST;
            cnt_r        <= 16'd0;
            pll_resetb_r <= 1'b0;
            sys_reset_r  <= 1'b1;
            ready_r      <= 1'b0;
            lock_lost_r  <= 1'b0;
            retry_cnt_r  <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_clr_s ? 16'd0 : (cnt_r + 16'd1);
            pll_resetb_r <= (state_nx_s != ST_PLLRST);
            sys_reset_r  <= (state_nx_s != ST_RUN);
            ready_r      <= (state_nx_s == ST_RUN);
            if (loss_inc_s) begin
                lock_lost_r <= 1'b1;
            end else begin
                lock_lost_r <= lock_lost_r;
            end
            if (retry_inc_s) begin
                retry_cnt_r <= sat_inc8(retry_cnt_r);
            end else begin
                retry_cnt_r <= retry_cnt_r;
            end
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of lock losses observed in RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_inc_s) begin
            loss_cnt_r <= sat_inc8(loss_cnt_r);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign LOSS_COUNT = loss_cnt_r;
`else
    assign LOSS_COUNT = 8'd0;
`endif

    assign PLL_RESETB  = pll_resetb_r;
    assign SYS_RESET   = sys_reset_r;
    assign READY       = ready_r;
    assign LOCK_LOST   = lock_lost_r;
    assign RETRY_COUNT = retry_cnt_r;

endmodule
